// File: rtl/vote_pkg.sv
// ============================================================================
// vote_pkg : shared types and helpers for the ballot tally controller
// Rev 1.0
// ============================================================================
`default_nettype none

package vote_pkg;

    // Widest ballot vector the one-hot helper accepts.
    localparam int MAX_CAND = 32;

    typedef enum logic [1:0] {
        OPEN = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Candidate index width; never narrower than one bit.
    function automatic int cand_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Exactly one bit set; an all-zero vector is not one-hot.
    function automatic logic is_onehot(input logic [MAX_CAND-1:0] vec);
        return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vote_max_scan.sv
// ============================================================================
// vote_max_scan : serial arg-max over candidate counts, one operand per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module vote_max_scan
    import vote_pkg::*;
#(
    parameter int NUM_CAND = 3,
    parameter int CNT_W    = 8,
    parameter int CAND_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    input  logic              start,
    input  logic [CAND_W-1:0] idx,
    input  logic [CNT_W-1:0]  cnt_in,
    output logic [CAND_W-1:0] best_idx,
    output logic [CNT_W-1:0]  best_cnt,
    output logic              tie
);

    // Operand is registered first so the count mux and the comparator sit in
    // separate cycles; this stage is the extra cycle of scan latency.
    logic              op_valid_q, op_valid_d;
    logic              op_start_q, op_start_d;
    logic [CAND_W-1:0] op_idx_q,   op_idx_d;
    logic [CNT_W-1:0]  op_cnt_q,   op_cnt_d;

    logic [CAND_W-1:0] best_idx_q, best_idx_d;
    logic [CNT_W-1:0]  best_cnt_q, best_cnt_d;
    logic              tie_q,      tie_d;

    always_comb begin
        op_valid_d = step;
        op_start_d = start;
        op_idx_d   = idx;
        op_cnt_d   = cnt_in;
        best_idx_d = best_idx_q;
        best_cnt_d = best_cnt_q;
        tie_d      = tie_q;

        if (op_valid_q) begin
            if (op_start_q) begin
                best_idx_d = op_idx_q;
                best_cnt_d = op_cnt_q;
                tie_d      = 1'b0;
            end else if (op_cnt_q > best_cnt_q) begin
                best_idx_d = op_idx_q;
                best_cnt_d = op_cnt_q;
                tie_d      = 1'b0;
            end else if (op_cnt_q == best_cnt_q) begin
                // Strictly-greater replacement keeps the lowest index on a tie.
                tie_d      = 1'b1;
            end
        end

        if (clear) begin
            op_valid_d = 1'b0;
            op_start_d = 1'b0;
            op_idx_d   = '0;
            op_cnt_d   = '0;
            best_idx_d = '0;
            best_cnt_d = '0;
            tie_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_valid_q <= 1'b0;
            op_start_q <= 1'b0;
            op_idx_q   <= '0;
            op_cnt_q   <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            tie_q      <= 1'b0;
        end else begin
            op_valid_q <= op_valid_d;
            op_start_q <= op_start_d;
            op_idx_q   <= op_idx_d;
            op_cnt_q   <= op_cnt_d;
            best_idx_q <= best_idx_d;
            best_cnt_q <= best_cnt_d;
            tie_q      <= tie_d;
        end
    end

    assign best_idx = best_idx_q;
    assign best_cnt = best_cnt_q;
    assign tie      = tie_q;

endmodule

`default_nettype wire

// File: rtl/vote_tally_seq.sv
// ============================================================================
// vote_tally_seq : one-hot ballot tally with saturating counters and serial winner scan
// Rev 1.0
// ============================================================================
`default_nettype none

module vote_tally_seq
    import vote_pkg::*;
#(
    parameter int  NUM_CAND = 3,
    parameter int  CNT_W    = 8,
    localparam int CAND_W   = cand_w(NUM_CAND)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ballot_valid,
    output logic                ballot_ready,
    input  logic [NUM_CAND-1:0] ballot_vec,
    input  logic                close_req,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [CAND_W-1:0]   winner_idx,
    output logic [CNT_W-1:0]    winner_cnt,
    output logic                tie,
    output logic [CNT_W-1:0]    spoiled_cnt,
    output logic                sat,
    output logic                busy
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CAND_W-1:0] LAST_IDX = CAND_W'(NUM_CAND - 1);

    state_t            state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CAND];
    logic [CNT_W-1:0]  cnt_d [NUM_CAND];
    logic [CNT_W-1:0]  spoiled_q, spoiled_d;
    logic              sat_q,     sat_d;
    logic [CAND_W-1:0] idx_q,     idx_d;
    logic              drain_q,   drain_d;

    logic              ballot_onehot;
    logic              scan_step;
    logic              scan_clear;

    assign ballot_onehot = is_onehot(MAX_CAND'(ballot_vec));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        spoiled_d = spoiled_q;
        sat_d     = sat_q;
        idx_d     = idx_q;
        drain_d   = drain_q;

        case (state_q)
            OPEN: begin
                if (ballot_valid) begin
                    if (ballot_onehot) begin
                        for (int i = 0; i < NUM_CAND; i++) begin
                            if (ballot_vec[i]) begin
                                if (cnt_q[i] == CNT_MAX) sat_d = 1'b1;
                                else                     cnt_d[i] = cnt_q[i] + 1'b1;
                            end
                        end
                    end else begin
                        if (spoiled_q == CNT_MAX) sat_d = 1'b1;
                        else                      spoiled_d = spoiled_q + 1'b1;
                    end
                end
                if (close_req) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    drain_d = 1'b0;
                end
            end
            SCAN: begin
                // One extra cycle after the last index lets the comparator
                // absorb the final registered operand.
                if (drain_q) begin
                    state_d = DONE;
                    drain_d = 1'b0;
                end else if (idx_q == LAST_IDX) begin
                    drain_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d   = OPEN;
                    spoiled_d = '0;
                    sat_d     = 1'b0;
                    idx_d     = '0;
                    for (int i = 0; i < NUM_CAND; i++) cnt_d[i] = '0;
                end
            end
            default: state_d = OPEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= OPEN;
            spoiled_q <= '0;
            sat_q     <= 1'b0;
            idx_q     <= '0;
            drain_q   <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            spoiled_q <= spoiled_d;
            sat_q     <= sat_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
            for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign scan_step  = (state_q == SCAN) && !drain_q;
    assign scan_clear = (state_q == DONE) && result_ready;

    vote_max_scan #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W),
        .CAND_W   (CAND_W)
    ) u_max_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (scan_clear),
        .step     (scan_step),
        .start    (idx_q == '0),
        .idx      (idx_q),
        .cnt_in   (cnt_q[idx_q]),
        .best_idx (winner_idx),
        .best_cnt (winner_cnt),
        .tie      (tie)
    );

    assign ballot_ready = (state_q == OPEN);
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q != OPEN);
    assign spoiled_cnt  = spoiled_q;
    assign sat          = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_vote_tally_seq.sv
// ============================================================================
// tb_vote_tally_seq : randomized and directed bench with a behavioural tally model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vote_tally_seq;

    localparam int N    = 3;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ballot_valid = 1'b0;
    logic         ballot_ready;
    logic [N-1:0] ballot_vec = '0;
    logic         close_req = 1'b0;
    logic         result_valid;
    logic         result_ready = 1'b0;
    logic [1:0]   winner_idx;
    logic [CW-1:0] winner_cnt;
    logic         tie;
    logic [CW-1:0] spoiled_cnt;
    logic         sat;
    logic         busy;

    always #5 clk = ~clk;

    vote_tally_seq #(.NUM_CAND(N), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ballot_valid (ballot_valid),
        .ballot_ready (ballot_ready),
        .ballot_vec   (ballot_vec),
        .close_req    (close_req),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .winner_idx   (winner_idx),
        .winner_cnt   (winner_cnt),
        .tie          (tie),
        .spoiled_cnt  (spoiled_cnt),
        .sat          (sat),
        .busy         (busy)
    );

    // ---------------- behavioural model: 0 open, 1 scanning, 2 result held
    int m_cnt [N];
    int m_spoil = 0;
    bit m_sat = 1'b0;
    int m_state = 0;
    int m_left = 0;
    int m_widx = 0;
    int m_wcnt = 0;
    bit m_tie = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_spoil = 0; m_sat = 0; m_state = 0;
            m_widx = 0; m_wcnt = 0; m_tie = 0;
        end else begin
            case (m_state)
                0: begin
                    if (ballot_valid) begin
                        if ($countones(ballot_vec) == 1) begin
                            for (int i = 0; i < N; i++)
                                if (ballot_vec[i]) begin
                                    if (m_cnt[i] == CMAX) m_sat = 1; else m_cnt[i]++;
                                end
                        end else begin
                            if (m_spoil == CMAX) m_sat = 1; else m_spoil++;
                        end
                    end
                    if (close_req) begin m_state = 1; m_left = N + 1; end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        int mx, nmx;
                        mx = -1; nmx = 0;
                        for (int i = 0; i < N; i++) if (m_cnt[i] > mx) begin mx = m_cnt[i]; m_widx = i; end
                        for (int i = 0; i < N; i++) if (m_cnt[i] == mx) nmx++;
                        m_wcnt = mx;
                        m_tie = (nmx > 1);
                        m_state = 2;
                    end
                end
                default: begin
                    if (result_ready) begin
                        foreach (m_cnt[i]) m_cnt[i] = 0;
                        m_spoil = 0; m_sat = 0; m_state = 0;
                        m_widx = 0; m_wcnt = 0; m_tie = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- hand-computed expectations armed by the stimulus
    int lit_seq = 0;
    int lit_idx, lit_cnt, lit_tie, lit_spoil, lit_sat;
    int tmo_cnt = 0;
    bit tb_done = 1'b0;

    // ---------------- single compare process; sole owner of the counters
    int n_checks = 0;
    int n_errors = 0;
    int lit_ack = 0;
    int tmo_ack = 0;
    int scan_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ballot_ready", int'(ballot_ready), int'(m_state == 0));
        chk("busy",         int'(busy),         int'(m_state != 0));
        chk("result_valid", int'(result_valid), int'(m_state == 2));
        chk("spoiled_cnt",  int'(spoiled_cnt),  m_spoil);
        chk("sat",          int'(sat),          int'(m_sat));
        if (m_state != 1) begin
            chk("winner_idx", int'(winner_idx), m_widx);
            chk("winner_cnt", int'(winner_cnt), m_wcnt);
            chk("tie",        int'(tie),        int'(m_tie));
        end

        if (busy && !result_valid) scan_cyc++;
        else if (result_valid && scan_cyc != 0) begin
            chk("scan_latency", scan_cyc, N + 1);
            scan_cyc = 0;
        end else if (!busy) scan_cyc = 0;

        if (result_valid && lit_seq != lit_ack) begin
            chk("lit_winner_idx", int'(winner_idx),  lit_idx);
            chk("lit_winner_cnt", int'(winner_cnt),  lit_cnt);
            chk("lit_tie",        int'(tie),         lit_tie);
            chk("lit_spoiled",    int'(spoiled_cnt), lit_spoil);
            chk("lit_sat",        int'(sat),         lit_sat);
            lit_ack = lit_seq;
        end

        if (tmo_cnt != tmo_ack) begin
            chk("result_timeout", tmo_cnt - tmo_ack, 0);
            tmo_ack = tmo_cnt;
        end

        if (tb_done) begin
            if (lit_seq != lit_ack) chk("lit_never_seen", lit_seq - lit_ack, 0);
            $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
            $finish;
        end
    end

    // ---------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] v, input bit cl);
        ballot_valid = 1'b1; ballot_vec = v; close_req = cl;
        tick();
        ballot_valid = 1'b0; close_req = 1'b0;
    endtask

    task automatic close_only();
        close_req = 1'b1;
        tick();
        close_req = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!result_valid && n < 40) begin tick(); n++; end
        if (!result_valid) tmo_cnt++;
    endtask

    task automatic take();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic arm(input int i, input int c, input int t, input int s, input int st);
        lit_idx = i; lit_cnt = c; lit_tie = t; lit_spoil = s; lit_sat = st;
        lit_seq++;
    endtask

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Majority for candidate 1.
        arm(1, 3, 0, 0, 0);
        send(3'b001, 0); send(3'b010, 0); send(3'b010, 0); send(3'b100, 0); send(3'b010, 0);
        close_only();
        wait_result();
        take();

        // Spoiled ballots and a tie resolved to the lowest index; close with last ballot.
        arm(0, 1, 1, 2, 0);
        send(3'b001, 0); send(3'b100, 0); send(3'b000, 0); send(3'b011, 1);
        wait_result();
        take();

        // Empty poll, result held while the consumer stalls.
        arm(0, 0, 1, 0, 0);
        close_only();
        wait_result();
        repeat (5) tick();
        take();

        // Saturation at the 4-bit limit.
        arm(2, 15, 0, 0, 1);
        repeat (20) send(3'b100, 0);
        close_only();
        wait_result();
        take();

        // Ballot with close in the same cycle, then ballots refused during the scan.
        arm(2, 1, 0, 0, 0);
        send(3'b100, 1);
        ballot_valid = 1'b1; ballot_vec = 3'b001; close_req = 1'b1;
        repeat (2) tick();
        ballot_valid = 1'b0; close_req = 1'b0;
        wait_result();
        take();

        // Reset while the scan is on index 1.
        send(3'b001, 0); send(3'b001, 0);
        close_only();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        arm(1, 1, 0, 0, 0);
        send(3'b010, 1);
        wait_result();
        take();

        // Randomized polls with noise during scan and occasional mid-poll reset.
        for (int p = 0; p < 30; p++) begin
            int nb;
            nb = $urandom_range(0, 40);
            for (int b = 0; b < nb; b++) begin
                logic [N-1:0] v;
                if ($urandom_range(0, 3) != 0) begin
                    v = '0;
                    v[($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 2)] = 1'b1;
                end else begin
                    v = N'($urandom_range(0, 7));
                end
                ballot_valid = ($urandom_range(0, 3) != 0);
                ballot_vec   = v;
                tick();
            end
            ballot_valid = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                close_only();
                tick();
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                continue;
            end
            close_only();
            for (int s = 0; s < 3; s++) begin
                ballot_valid = $urandom_range(0, 1);
                ballot_vec   = N'($urandom_range(0, 7));
                close_req    = $urandom_range(0, 1);
                tick();
            end
            ballot_valid = 1'b0; close_req = 1'b0;
            wait_result();
            repeat ($urandom_range(0, 3)) tick();
            take();
        end

        repeat (3) tick();
        tb_done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
